// File: rtl/maxpool_forward_pkg.sv
// Shared float type, signed-zero constants and the sign-magnitude ordering
// used by the max-pooling datapath.
package maxpool_forward_pkg;

  typedef logic [31:0] float_t;

  localparam float_t FP_POS_ZERO = 32'h0000_0000;
  localparam float_t FP_NEG_ZERO = 32'h8000_0000;

  // True when a >= b in sign-magnitude order. Raw bit patterns are compared,
  // so NaN/Inf need no special handling and +0 beats -0 via the sign rule.
  function automatic logic fp_ge(input float_t a, input float_t b);
    logic ge;
    if (a[31] != b[31]) begin
      ge = ~a[31];
    end else if (a[31] == 1'b0) begin
      ge = (a[30:0] >= b[30:0]);
    end else begin
      ge = (a[30:0] <= b[30:0]);
    end
    return ge;
  endfunction

endpackage

// File: rtl/maxpool_forward_fp_max2.sv
// Single-lane combinational float maximum.
module fp_max2
  import maxpool_forward_pkg::*;
(
  input  float_t a,
  input  float_t b,
  output float_t y
);

  assign y = fp_ge(a, b) ? a : b;

endmodule

// File: rtl/maxpool_forward.sv
// Streaming max-pool: reduces POOL consecutive input vectors into one output
// vector by a per-lane float maximum, with valid/ready handshakes and a
// global clock enable.
module maxpool_forward
  import maxpool_forward_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int POOL  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WIDTH-1:0]   in_data,
  input  logic [7:0]            in_id,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WIDTH-1:0]   out_data,
  output logic [7:0]            out_id
);

  localparam int            CW       = $clog2(POOL);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(POOL - 1);

  logic [CW-1:0]         cnt_r;
  logic                  cnt_last_r;   // registered cnt == POOL-1 keeps in_ready compare-free
  logic [32*WIDTH-1:0]   acc_r;
  logic [7:0]            tag_r;
  logic [32*WIDTH-1:0]   out_data_r;
  logic [7:0]            out_id_r;
  logic                  out_valid_r;

  logic [CW-1:0]         cnt_s;
  logic                  cnt_last_s;
  logic [32*WIDTH-1:0]   acc_s;
  logic [7:0]            tag_s;
  logic [32*WIDTH-1:0]   out_data_s;
  logic [7:0]            out_id_s;
  logic                  out_valid_s;
  logic [32*WIDTH-1:0]   max_s;
  logic                  in_ready_s;
  logic                  in_fire_s;
  logic                  out_fire_s;
  logic                  done_s;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g = g + 1) begin : g_lane
      fp_max2 u_max (
        .a (acc_r[32*g +: 32]),
        .b (in_data[32*g +: 32]),
        .y (max_s[32*g +: 32])
      );
    end
  endgenerate

  assign in_ready_s = ~cnt_last_r | ~out_valid_r | out_ready;
  assign in_fire_s  = clk_en & in_valid & in_ready_s;
  assign out_fire_s = clk_en & out_valid_r & out_ready;
  assign done_s     = in_fire_s & cnt_last_r;

  // Next-state for window counter, accumulator, tag and output registers.
  always_comb begin
    cnt_s       = cnt_r;
    cnt_last_s  = cnt_last_r;
    acc_s       = acc_r;
    tag_s       = tag_r;
    out_data_s  = out_data_r;
    out_id_s    = out_id_r;
    out_valid_s = out_valid_r;
    if (in_fire_s) begin
      if (cnt_last_r) begin
        out_data_s = max_s;
        out_id_s   = tag_r;
        cnt_s      = CNT_ZERO;
        cnt_last_s = 1'b0;
      end else begin
        if (cnt_r == CNT_ZERO) begin
          acc_s = in_data;
          tag_s = in_id;
        end else begin
          acc_s = max_s;
        end
        cnt_s      = cnt_r + CNT_ONE;
        cnt_last_s = ((cnt_r + CNT_ONE) == CNT_LAST);
      end
    end else begin
      cnt_s = cnt_r;
    end
    if (done_s) begin
      out_valid_s = 1'b1;
    end else if (out_fire_s) begin
      out_valid_s = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
    end
  end

  // State registers: async clear, frozen while clk_en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r       <= CNT_ZERO;
      cnt_last_r  <= 1'b0;
      acc_r       <= {WIDTH{FP_POS_ZERO}};
      tag_r       <= 8'h00;
      out_data_r  <= {WIDTH{FP_POS_ZERO}};
      out_id_r    <= 8'h00;
      out_valid_r <= 1'b0;
    end else if (clk_en) begin
      cnt_r       <= cnt_s;
      cnt_last_r  <= cnt_last_s;
      acc_r       <= acc_s;
      tag_r       <= tag_s;
      out_data_r  <= out_data_s;
      out_id_r    <= out_id_s;
      out_valid_r <= out_valid_s;
    end else begin
      cnt_r       <= cnt_r;
      cnt_last_r  <= cnt_last_r;
      acc_r       <= acc_r;
      tag_r       <= tag_r;
      out_data_r  <= out_data_r;
      out_id_r    <= out_id_r;
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_id    = out_id_r;

endmodule

// File: tb/tb_maxpool_forward.sv
// Directed bench for maxpool_forward (WIDTH=2, POOL=2): a table of two-vector
// windows with hand-computed maxima, then handshake/reset/stall sequences.
module tb_maxpool_forward;

  localparam int WIDTH = 2;
  localparam int POOL  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                clk_en;
  logic                in_valid;
  logic                in_ready;
  logic [32*WIDTH-1:0] in_data;
  logic [7:0]          in_id;
  logic                out_valid;
  logic                out_ready;
  logic [32*WIDTH-1:0] out_data;
  logic [7:0]          out_id;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  maxpool_forward #(.WIDTH(WIDTH), .POOL(POOL)) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_id     (in_id),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  typedef struct {
    logic [31:0] a0, a1;   // first vector, lanes 0/1
    logic [31:0] b0, b1;   // second vector, lanes 0/1
    logic [31:0] e0, e1;   // expected maxima
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] id0;

    vecs[0] = '{32'h3F800000, 32'hBF800000, 32'h40000000, 32'hC0000000, 32'h40000000, 32'hBF800000};
    vecs[1] = '{32'h80000000, 32'h00000000, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000};
    vecs[2] = '{32'hC0000000, 32'h40400000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40400000};
    vecs[3] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h80000001, 32'h7FC00000, 32'h80000001};
    vecs[4] = '{32'h12345678, 32'h80000000, 32'h12345678, 32'h80000001, 32'h12345678, 32'h80000000};

    reset     = 1'b1;
    clk_en    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = 64'h0;
    in_id     = 8'h00;
    tick();
    tick();
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_out_data", out_data, 64'h0);
    check("rst_out_id", {56'h0, out_id}, 64'h0);
    check("rst_in_ready", {63'h0, in_ready}, 64'h1);
    reset = 1'b0;
    tick();

    // Table of two-vector windows, downstream always ready.
    for (int i = 0; i < 5; i++) begin
      id0 = 8'(i * 4 + 1);
      in_valid = 1'b1;
      in_data  = {vecs[i].a1, vecs[i].a0};
      in_id    = id0;
      tick();
      check("tbl_ov_first", {63'h0, out_valid}, 64'h0);
      in_data = {vecs[i].b1, vecs[i].b0};
      in_id   = id0 + 8'd1;
      tick();
      check("tbl_ov_last", {63'h0, out_valid}, 64'h1);
      check("tbl_data", out_data, {vecs[i].e1, vecs[i].e0});
      check("tbl_id", {56'h0, out_id}, {56'h0, id0});
      in_valid = 1'b0;
      tick();
      check("tbl_ov_drain", {63'h0, out_valid}, 64'h0);
    end

    // Backpressure: output held, in_ready drops only on a pending last vector.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {32'h40A00000, 32'h3F800000};
    in_id     = 8'd10;
    tick();
    in_data = {32'h40400000, 32'h40800000};
    in_id   = 8'd11;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_ov", {63'h0, out_valid}, 64'h1);
      check("bp_data", out_data, {32'h40A00000, 32'h40800000});
      check("bp_id", {56'h0, out_id}, 64'd10);
      check("bp_in_ready", {63'h0, in_ready}, 64'h1);
      tick();
    end
    in_valid = 1'b1;
    in_data  = {32'hC1200000, 32'h00000000};
    in_id    = 8'd12;
    tick();
    in_data = {32'hC0A00000, 32'h80000000};
    in_id   = 8'd13;
    check("bp_ready_low0", {63'h0, in_ready}, 64'h0);
    tick();
    check("bp_ready_low1", {63'h0, in_ready}, 64'h0);
    check("bp_id_held", {56'h0, out_id}, 64'd10);
    check("bp_data_held", out_data, {32'h40A00000, 32'h40800000});
    out_ready = 1'b1;
    #1;
    check("bp_ready_comb", {63'h0, in_ready}, 64'h1);
    tick();
    check("b2b_ov", {63'h0, out_valid}, 64'h1);
    check("b2b_id", {56'h0, out_id}, 64'd12);
    check("b2b_data", out_data, {32'hC0A00000, 32'h00000000});
    in_valid = 1'b0;
    tick();
    check("b2b_drain", {63'h0, out_valid}, 64'h0);

    // Continuous streaming: one output every two cycles, ids 0,2,4,6.
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = {32'(100 - k), 32'(k)};
      in_id   = 8'(k);
      tick();
      check("str_ov", {63'h0, out_valid}, 64'(k % 2));
      check("str_in_ready", {63'h0, in_ready}, 64'h1);
      if ((k % 2) == 1) begin
        check("str_id", {56'h0, out_id}, 64'(k - 1));
        check("str_data", out_data, {32'(101 - k), 32'(k)});
      end
    end
    in_valid = 1'b0;
    tick();
    check("str_drain", {63'h0, out_valid}, 64'h0);

    // Reset with a pending output and a partial window.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {32'h3F800000, 32'h3F800000};
    in_id     = 8'd30;
    tick();
    in_id = 8'd31;
    tick();
    check("rs_ov_pend", {63'h0, out_valid}, 64'h1);
    in_data = {32'h7F000000, 32'h7F000000};
    in_id   = 8'd32;
    tick();
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rs_ov_imm", {63'h0, out_valid}, 64'h0);
    check("rs_data_imm", out_data, 64'h0);
    check("rs_id_imm", {56'h0, out_id}, 64'h0);
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = {32'h3F800000, 32'h40000000};
    in_id     = 8'd40;
    tick();
    check("rs_first_ov", {63'h0, out_valid}, 64'h0);
    in_data = {32'h40000000, 32'h3F800000};
    in_id   = 8'd41;
    tick();
    check("rs_ov", {63'h0, out_valid}, 64'h1);
    check("rs_id", {56'h0, out_id}, 64'd40);
    check("rs_data", out_data, {32'h40000000, 32'h40000000});
    in_valid = 1'b0;
    tick();

    // Clock-enable stall with a pending output and a waiting input.
    in_valid = 1'b1;
    in_data  = {32'h3F800000, 32'h3F800000};
    in_id    = 8'd48;
    tick();
    in_id = 8'd49;
    tick();
    check("ce_ov_pre", {63'h0, out_valid}, 64'h1);
    clk_en  = 1'b0;
    in_data = {32'h3F800000, 32'h40400000};
    in_id   = 8'd50;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ce_ov_hold", {63'h0, out_valid}, 64'h1);
      check("ce_id_hold", {56'h0, out_id}, 64'd48);
      check("ce_data_hold", out_data, {32'h3F800000, 32'h3F800000});
    end
    clk_en = 1'b1;
    tick();
    check("ce_resume_ov", {63'h0, out_valid}, 64'h0);
    in_data = {32'h40800000, 32'h3F000000};
    in_id   = 8'd51;
    tick();
    check("ce_ov", {63'h0, out_valid}, 64'h1);
    check("ce_id", {56'h0, out_id}, 64'd50);
    check("ce_data", out_data, {32'h40800000, 32'h40400000});
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/maxpool_forward.md
MAXPOOL_FORWARD -- requirements
Module: maxpool_forward

Interface
REQ-001 SHALL have parameter WIDTH, default 8, lanes per vector.
REQ-002 SHALL have parameter POOL, default 2, vectors per pooling window; legal range 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clk_en  input  1  global stall; low freezes all state and outputs.
REQ-006 SHALL have port in_valid  input  1  upstream (ReLU stage) vector valid.
REQ-007 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-008 SHALL have port in_data  input  32 x WIDTH  IEEE-754 single-precision lanes.
REQ-009 SHALL have port in_id  input  8  vector tag.
REQ-010 SHALL have port out_valid  output  1  pooled vector valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts output.
REQ-012 SHALL have port out_data  output  32 x WIDTH  per-lane maximum over the window.
REQ-013 SHALL have port out_id  output  8  in_id of the first vector in the window.

Function
REQ-014 Input transfer SHALL occur on a clock edge with clk_en=1, in_valid=1, in_ready=1; output transfer with clk_en=1, out_valid=1, out_ready=1.
REQ-015 A window counter cnt (0..POOL-1) SHALL count accepted vectors in the current window.
REQ-016 On a transfer with cnt=0, the accumulator SHALL load in_data and the tag register SHALL load in_id.
REQ-017 On a transfer with 0<cnt<POOL-1, the accumulator SHALL load per-lane max(acc, in_data) and cnt SHALL increment.
REQ-018 On a transfer with cnt=POOL-1, out_data SHALL load per-lane max(acc, in_data), out_id SHALL load the tag (in_id if POOL were 1), out_valid SHALL be set, and cnt SHALL return to 0.
REQ-019 Latency SHALL be one cycle: out_valid rises on the edge that accepts the last window vector.
REQ-020 in_ready SHALL be 1 when cnt<POOL-1, or when out_valid=0, or when out_ready=1 (combinational; no comparison logic on this path).
REQ-021 An output transfer with no new window completion on the same edge SHALL clear out_valid; a simultaneous output transfer and window completion SHALL keep out_valid=1 with new data (back-to-back, no bubble).
REQ-022 out_data/out_id SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 Float max SHALL use sign-magnitude ordering: larger of two positives has larger magnitude bits; smaller of two negatives; any positive beats any negative; +0 (0x00000000) SHALL beat -0 (0x80000000); NaN/Inf compared as raw patterns, no special handling.
REQ-024 With clk_en=0, cnt, accumulator, tag, out_* and out_valid SHALL hold; no transfer occurs regardless of valid/ready.

Reset
REQ-025 Asserting reset SHALL immediately clear cnt, accumulator, tag, out_data, out_id and out_valid to 0, discarding any partial window or pending output.
REQ-026 The first vector accepted after reset deassertion SHALL start a new window (cnt=0 path).

Structure
REQ-027 A shared package SHALL hold the float_t typedef (32-bit), the FP_POS_ZERO/FP_NEG_ZERO constants and the sign-magnitude compare function.
REQ-028 One sub-module fp_max2 (two float_t in, one out, purely combinational) SHALL be instantiated WIDTH times.

Verification
REQ-029 POOL=2, lane0 inputs 0x3F800000 (1.0) then 0x40000000 (2.0), id 5 then 6 -> out lane0 0x40000000, out_id 5, out_valid one cycle after second accept.
REQ-030 Lane inputs 0xBF800000 (-1.0) and 0xC0000000 (-2.0) -> 0xBF800000; 0x80000000 and 0x00000000 -> 0x00000000.
REQ-031 out_ready=0 for 5 cycles after output -> out_data/out_id stable, in_ready=1 while cnt<POOL-1, in_ready=0 once the next window's last vector is pending.
REQ-032 Continuous in_valid, out_ready=1, POOL=2, 8 vectors -> 4 outputs, one every 2 cycles, no bubbles, ids 0,2,4,6.
REQ-033 Reset asserted after one vector of a window -> out_valid=0 immediately; next two vectors form a fresh window with first vector's id.
REQ-034 clk_en=0 for 3 cycles mid-window with in_valid=1 -> no state change; resumes correctly when clk_en=1.
